// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle CPU controller: opcodes, state encodings,
// datapath select codes and the control-vector layout.
package multicycle_control_pkg;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_J     = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_ADDI  = 3'b101;
    localparam logic [2:0] OP_JAL   = 3'b110;
    localparam logic [2:0] OP_JR    = 3'b111;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_RTEXE  = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_JR     = 4'd13;

    localparam logic [1:0] ALUB_REGB = 2'b00;
    localparam logic [1:0] ALUB_INC  = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_BOFF = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       jal;
        logic       reg_ra;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    // An instruction retires on the edge that returns the sequencer to FETCH.
    function automatic logic is_retire(input logic [3:0] cur, input logic [3:0] nxt);
        return (cur != S_FETCH) && (nxt == S_FETCH);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle. The controller is the master; the
// datapath supplies opcode, zero flag and the memory ready handshake.
interface multicycle_control_if #(parameter int CNT_W = 16);
    logic [2:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             branch;
    logic             pc_en;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             jal;
    logic             reg_ra;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_write, branch, pc_en,
               reg_write, reg_dst, mem_to_reg, jal, reg_ra, alu_src_a,
               alu_src_b, alu_op, pc_src, state, instr_count
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_write, branch, pc_en,
               reg_write, reg_dst, mem_to_reg, jal, reg_ra, alu_src_a,
               alu_src_b, alu_op, pc_src, state, instr_count
    );
endinterface

// File: rtl/multicycle_control_state_outputs.sv
// Moore decode of the sequencer state into the datapath control vector.
// ir_write/pc_write in FETCH are qualified by mem_ready so a stalled fetch loads nothing.
module mc_state_outputs
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state_s,
    input  logic       mem_ready,
    output ctrl_t      ctrl_s
);

    // State-to-control decode; unlisted fields and illegal states stay 0.
    always_comb begin
        ctrl_s = '0;
        case (state_s)
            S_FETCH: begin
                ctrl_s.mem_req   = 1'b1;
                ctrl_s.alu_src_b = ALUB_INC;
                ctrl_s.alu_op    = ALUOP_ADD;
                ctrl_s.ir_write  = mem_ready;
                ctrl_s.pc_write  = mem_ready;
            end
            S_DECODE: ctrl_s.alu_src_b = ALUB_BOFF;
            S_MEMADR, S_ADDIEX: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUB_IMM;
            end
            S_MEMRD: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_s.mem_req   = 1'b1;
                ctrl_s.mem_write = 1'b1;
                ctrl_s.iord      = 1'b1;
            end
            S_RTEXE: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUB_REGB;
                ctrl_s.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_op    = ALUOP_SUB;
                ctrl_s.branch    = 1'b1;
                ctrl_s.pc_src    = PCSRC_ALUOUT;
            end
            S_ADDIWB: ctrl_s.reg_write = 1'b1;
            S_JUMP: begin
                ctrl_s.pc_write = 1'b1;
                ctrl_s.pc_src   = PCSRC_JUMP;
            end
            S_JAL: begin
                ctrl_s.pc_write  = 1'b1;
                ctrl_s.pc_src    = PCSRC_JUMP;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.jal       = 1'b1;
                ctrl_s.reg_ra    = 1'b1;
            end
            S_JR: begin
                ctrl_s.pc_write = 1'b1;
                ctrl_s.pc_src   = PCSRC_REGA;
            end
            default: ctrl_s = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the 3-bit-opcode CPU: state register, next-state
// logic, reset gating of write strobes and the retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    logic [3:0]       state_r;
    logic [3:0]       state_next_s;
    logic [CNT_W-1:0] count_r;
    ctrl_t            ctrl_s;

    mc_state_outputs u_outputs (
        .state_s   (state_r),
        .mem_ready (bus.mem_ready),
        .ctrl_s    (ctrl_s)
    );

    // Next-state selection; memory states hold until mem_ready.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH:  state_next_s = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_RTYPE:     state_next_s = S_RTEXE;
                    OP_BEQ:       state_next_s = S_BEQ;
                    OP_ADDI:      state_next_s = S_ADDIEX;
                    OP_J:         state_next_s = S_JUMP;
                    OP_JAL:       state_next_s = S_JAL;
                    OP_JR:        state_next_s = S_JR;
                    default:      state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: state_next_s = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next_s = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_next_s = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTEXE:  state_next_s = S_ALUWB;
            S_ADDIEX: state_next_s = S_ADDIWB;
            default:  state_next_s = S_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Retired-instruction counter, wraps naturally at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (is_retire(state_r, state_next_s)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Strobes drop the moment reset rises, without waiting for a clock edge.
    assign bus.mem_req    = ctrl_s.mem_req   & ~reset;
    assign bus.mem_write  = ctrl_s.mem_write & ~reset;
    assign bus.ir_write   = ctrl_s.ir_write  & ~reset;
    assign bus.pc_write   = ctrl_s.pc_write  & ~reset;
    assign bus.reg_write  = ctrl_s.reg_write & ~reset;
    assign bus.pc_en      = (ctrl_s.pc_write | (ctrl_s.branch & bus.zero)) & ~reset;
    assign bus.iord       = ctrl_s.iord;
    assign bus.branch     = ctrl_s.branch;
    assign bus.reg_dst    = ctrl_s.reg_dst;
    assign bus.mem_to_reg = ctrl_s.mem_to_reg;
    assign bus.jal        = ctrl_s.jal;
    assign bus.reg_ra     = ctrl_s.reg_ra;
    assign bus.alu_src_a  = ctrl_s.alu_src_a;
    assign bus.alu_src_b  = ctrl_s.alu_src_b;
    assign bus.alu_op     = ctrl_s.alu_op;
    assign bus.pc_src     = ctrl_s.pc_src;
    assign bus.state      = state_r;
    assign bus.instr_count = count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a 4-bit counter so wrap is reachable.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [3:0] exp_cnt;

    multicycle_control_if #(.CNT_W(4)) bus ();

    multicycle_control #(.CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (bus.state !== 4'd0 || bus.instr_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: state=%0d count=%0d, want 0/0", bus.state, bus.instr_count);
        end
        tests++;
        if (bus.mem_req !== 1'b0 || bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes: mem_req=%b ir_write=%b pc_write=%b, want 000",
                     bus.mem_req, bus.ir_write, bus.pc_write);
        end
        tick();
        reset = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic test_back_to_back();
        bus.mem_ready = 1'b0;
        #1;
        tests++;
        if (bus.mem_req !== 1'b1 || bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0) begin
            fails++;
            $display("FAIL fetch_stall: mem_req=%b ir_write=%b pc_write=%b, want 100",
                     bus.mem_req, bus.ir_write, bus.pc_write);
        end
        tick();
        tests++;
        if (bus.state !== 4'd0) begin
            fails++;
            $display("FAIL fetch_hold: state=%0d, want 0", bus.state);
        end
        bus.mem_ready = 1'b1;
        bus.op = OP_J;
        for (int k = 0; k < 16; k++) begin
            tick();
            tick();
            tests++;
            if (bus.state !== 4'd11 || bus.pc_write !== 1'b1 || bus.pc_src !== 2'b10) begin
                fails++;
                $display("FAIL jump_state[%0d]: state=%0d pc_write=%b pc_src=%b, want 11/1/10",
                         k, bus.state, bus.pc_write, bus.pc_src);
            end
            tick();
            exp_cnt = exp_cnt + 4'd1;
            tests++;
            if (bus.state !== 4'd0 || bus.instr_count !== exp_cnt) begin
                fails++;
                $display("FAIL jump_count[%0d]: state=%0d count=%0d, want 0/%0d",
                         k, bus.state, bus.instr_count, exp_cnt);
            end
        end
        tests++;
        if (bus.instr_count !== 4'd0) begin
            fails++;
            $display("FAIL count_wrap: count=%0d, want 0", bus.instr_count);
        end
    endtask

    task automatic test_rtype();
        logic [3:0] st [5];
        logic [4:0] rw;
        st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        rw = 5'b01000;  // bit i = reg_write/reg_dst expected in cycle i
        bus.op = OP_RTYPE;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (bus.state !== st[i] || bus.reg_write !== rw[i] || bus.reg_dst !== rw[i]) begin
                fails++;
                $display("FAIL rtype[%0d]: state=%0d reg_write=%b reg_dst=%b, want %0d/%b/%b",
                         i, bus.state, bus.reg_write, bus.reg_dst, st[i], rw[i], rw[i]);
            end
            if (i == 2) begin
                tests++;
                if (bus.alu_op !== 2'b10 || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b00) begin
                    fails++;
                    $display("FAIL rtype_exe: alu_op=%b src_a=%b src_b=%b, want 10/1/00",
                             bus.alu_op, bus.alu_src_a, bus.alu_src_b);
                end
            end
            if (i < 4) tick();
        end
        exp_cnt = exp_cnt + 4'd1;
        tests++;
        if (bus.instr_count !== exp_cnt) begin
            fails++;
            $display("FAIL rtype_count: count=%0d, want %0d", bus.instr_count, exp_cnt);
        end
    endtask

    task automatic test_lw_stall();
        logic [3:0] st [8];
        logic [7:0] rdy;
        logic [7:0] wb;
        st  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        rdy = 8'b1110_0011;  // bit i = mem_ready driven in cycle i
        wb  = 8'b0100_0000;  // bit i = reg_write & mem_to_reg expected in cycle i
        bus.op = OP_LW;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = rdy[i];
            #1;
            tests++;
            if (bus.state !== st[i] || bus.reg_write !== wb[i] || bus.mem_to_reg !== wb[i]) begin
                fails++;
                $display("FAIL lw[%0d]: state=%0d reg_write=%b mem_to_reg=%b, want %0d/%b/%b",
                         i, bus.state, bus.reg_write, bus.mem_to_reg, st[i], wb[i], wb[i]);
            end
            if (i == 4) begin
                tests++;
                if (bus.mem_req !== 1'b1 || bus.iord !== 1'b1 || bus.mem_write !== 1'b0) begin
                    fails++;
                    $display("FAIL lw_memrd: mem_req=%b iord=%b mem_write=%b, want 1/1/0",
                             bus.mem_req, bus.iord, bus.mem_write);
                end
            end
            if (i < 7) tick();
        end
        exp_cnt = exp_cnt + 4'd1;
        tests++;
        if (bus.instr_count !== exp_cnt) begin
            fails++;
            $display("FAIL lw_count: count=%0d, want %0d", bus.instr_count, exp_cnt);
        end
    endtask

    task automatic test_beq();
        logic z;
        bus.op = OP_BEQ;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            z = (k == 0) ? 1'b1 : 1'b0;
            bus.zero = z;
            tick();
            #1;
            tests++;
            if (bus.state !== 4'd1 || bus.pc_en !== 1'b0) begin
                fails++;
                $display("FAIL beq_decode[%0d]: state=%0d pc_en=%b, want 1/0", k, bus.state, bus.pc_en);
            end
            tick();
            tests++;
            if (bus.state !== 4'd8 || bus.pc_en !== z || bus.pc_src !== 2'b01 || bus.alu_op !== 2'b01) begin
                fails++;
                $display("FAIL beq_exe[%0d]: state=%0d pc_en=%b pc_src=%b alu_op=%b, want 8/%b/01/01",
                         k, bus.state, bus.pc_en, bus.pc_src, bus.alu_op, z);
            end
            tick();
            exp_cnt = exp_cnt + 4'd1;
            tests++;
            if (bus.state !== 4'd0 || bus.instr_count !== exp_cnt) begin
                fails++;
                $display("FAIL beq_done[%0d]: state=%0d count=%0d, want 0/%0d",
                         k, bus.state, bus.instr_count, exp_cnt);
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jal_jr();
        bus.mem_ready = 1'b1;
        bus.op = OP_JAL;
        tick();
        tick();
        tests++;
        if (bus.state !== 4'd12 || bus.pc_write !== 1'b1 || bus.reg_write !== 1'b1 ||
            bus.jal !== 1'b1 || bus.reg_ra !== 1'b1 || bus.pc_src !== 2'b10) begin
            fails++;
            $display("FAIL jal: state=%0d pc_write=%b reg_write=%b jal=%b reg_ra=%b pc_src=%b, want 12/1/1/1/1/10",
                     bus.state, bus.pc_write, bus.reg_write, bus.jal, bus.reg_ra, bus.pc_src);
        end
        tick();
        bus.op = OP_JR;
        tick();
        tick();
        tests++;
        if (bus.state !== 4'd13 || bus.pc_src !== 2'b11 || bus.reg_write !== 1'b0 ||
            bus.pc_write !== 1'b1 || bus.jal !== 1'b0) begin
            fails++;
            $display("FAIL jr: state=%0d pc_src=%b reg_write=%b pc_write=%b jal=%b, want 13/11/0/1/0",
                     bus.state, bus.pc_src, bus.reg_write, bus.pc_write, bus.jal);
        end
        tick();
        exp_cnt = exp_cnt + 4'd2;
        tests++;
        if (bus.state !== 4'd0 || bus.instr_count !== exp_cnt) begin
            fails++;
            $display("FAIL jal_jr_count: state=%0d count=%0d, want 0/%0d", bus.state, bus.instr_count, exp_cnt);
        end
    endtask

    task automatic test_latency();
        logic [2:0] ops [2];
        logic [3:0] third [2];
        ops   = '{OP_SW, OP_ADDI};
        third = '{4'd5, 4'd10};
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.op = ops[k];
            tick();
            tick();
            tests++;
            if (bus.state !== (k == 0 ? 4'd2 : 4'd9) || bus.alu_src_b !== 2'b10 || bus.alu_src_a !== 1'b1) begin
                fails++;
                $display("FAIL lat_addr[%0d]: state=%0d src_b=%b src_a=%b", k, bus.state, bus.alu_src_b, bus.alu_src_a);
            end
            tick();
            tests++;
            if (bus.state !== third[k] || bus.mem_write !== (k == 0) || bus.reg_write !== (k == 1) ||
                bus.reg_dst !== 1'b0) begin
                fails++;
                $display("FAIL lat_last[%0d]: state=%0d mem_write=%b reg_write=%b reg_dst=%b, want %0d",
                         k, bus.state, bus.mem_write, bus.reg_write, bus.reg_dst, third[k]);
            end
            tick();
            exp_cnt = exp_cnt + 4'd1;
            tests++;
            if (bus.state !== 4'd0 || bus.instr_count !== exp_cnt) begin
                fails++;
                $display("FAIL lat_done[%0d]: state=%0d count=%0d, want 0/%0d", k, bus.state, bus.instr_count, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_memrd();
        bus.op = OP_LW;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        tick();
        tick();
        #1;
        tests++;
        if (bus.state !== 4'd3 || bus.mem_req !== 1'b1) begin
            fails++;
            $display("FAIL mid_memrd: state=%0d mem_req=%b, want 3/1", bus.state, bus.mem_req);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (bus.mem_req !== 1'b0 || bus.mem_write !== 1'b0 || bus.ir_write !== 1'b0 ||
            bus.pc_write !== 1'b0 || bus.pc_en !== 1'b0 || bus.reg_write !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: mem_req=%b mem_write=%b ir_write=%b pc_write=%b pc_en=%b reg_write=%b, want all 0",
                     bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_en, bus.reg_write);
        end
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if (bus.state !== 4'd0 || bus.instr_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_release: state=%0d count=%0d, want 0/0", bus.state, bus.instr_count);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_cnt = 4'd0;
        reset = 1'b1;
        bus.op = 3'b000;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        test_reset();
        test_back_to_back();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_jal_jr();
        test_latency();
        test_reset_mid_memrd();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle control FSM for the 3-bit-opcode CPU. It replaces single-cycle decode with a sequencer that shares one ALU and one unified memory port across fetch, decode, execute, memory and writeback steps. It drives all datapath mux selects and write strobes, stalls on a memory ready handshake, and counts retired instructions.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  3  opcode from the instruction register; valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current access (read data valid or write accepted)
mem_req  out  1  memory access request
mem_write  out  1  write qualifier for mem_req
iord  out  1  address select: 0=PC, 1=ALUOut
ir_write  out  1  load instruction register
pc_write  out  1  unconditional PC load
branch  out  1  conditional branch state
pc_en  out  1  pc_write | (branch & zero)
reg_write  out  1  register file write enable
reg_dst  out  1  1=rd, 0=rt
mem_to_reg  out  1  1=memory data register, 0=ALUOut
jal  out  1  write-data select = PC (link)
reg_ra  out  1  write-address select = return-address register
alu_src_a  out  1  0=PC, 1=register A
alu_src_b  out  2  00=register B, 01=increment constant, 10=sign-extended imm, 11=branch offset
alu_op  out  2  00=add, 01=subtract, 10=funct-decoded
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=register A (jr)
state  out  4  current state, for debug
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Opcodes: 000 R-type, 001 lw, 010 sw, 011 j, 100 beq, 101 addi, 110 jal, 111 jr.
- Moore outputs decoded from state. Outputs not listed for a state are 0.
- Reset asserted: state=FETCH, instr_count=0. All strobes are forced 0 immediately, independent of clk: mem_req, mem_write, ir_write, pc_write, pc_en, reg_write. A reset mid-instruction abandons the instruction; nothing is retired.
- FETCH(0): mem_req=1, alu_src_b=01, alu_op=00. ir_write and pc_write are 1 only when mem_ready=1. Holds while mem_ready=0; goes to DECODE on mem_ready.
- DECODE(1): alu_src_b=11 (branch target precomputed into ALUOut). Next state:
  - 001/010 → MEMADR
  - 000 → RTEXE
  - 100 → BEQ
  - 101 → ADDIEX
  - 011 → JUMP
  - 110 → JAL
  - 111 → JR
- MEMADR(2): alu_src_a=1, alu_src_b=10. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD(3): mem_req=1, iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWR(5): mem_req=1, mem_write=1, iord=1, held until mem_ready. Goes to FETCH.
- RTEXE(6): alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB(7): reg_write=1, reg_dst=1. Goes to FETCH.
- BEQ(8): alu_src_a=1, alu_op=01, branch=1, pc_src=01. Goes to FETCH. pc_en follows zero combinationally.
- ADDIEX(9): alu_src_a=1, alu_src_b=10. Goes to ADDIWB.
- ADDIWB(10): reg_write=1, reg_dst=0. Goes to FETCH.
- JUMP(11): pc_write=1, pc_src=10. Goes to FETCH.
- JAL(12): pc_write=1, pc_src=10, reg_write=1, jal=1, reg_ra=1. Goes to FETCH. The link value is the PC already incremented in FETCH.
- JR(13): pc_write=1, pc_src=11. Goes to FETCH.
- Encodings 14 and 15 are unreachable and recover to FETCH on the next edge with all outputs 0.
- instr_count increments by 1 on each clk edge where the next state is FETCH from a non-FETCH state. At all-ones it wraps to 0.
- mem_ready is ignored when mem_req=0. mem_ready held high gives zero stall cycles.
- Latency with mem_ready=1:
  - beq, j, jal, jr: 3 cycles
  - R-type, sw, addi: 4 cycles
  - lw: 5 cycles
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.

Decomposition:
- Shared package: opcode constants, state encodings, and the alu_src_b, pc_src and alu_op code constants. The datapath and the bench use the same names.
- One sub-module, mc_state_outputs: combinational state → control-vector decode, including the mem_ready gating of ir_write and pc_write. The top keeps the state register, next-state logic, reset forcing and counter.

Test Plan:
- Reset mid-MEMRD (lw, mem_ready=0) → within the same cycle all strobes=0; after release state=0, instr_count=0.
- R-type (op=000), mem_ready=1 → states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_count +1 after 4 cycles.
- lw with mem_ready=0 for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0 (7 cycles); mem_to_reg=1 with reg_write=1 in state 4.
- beq with zero=1, then with zero=0 → pc_en=1/0 in state 8, pc_src=01 in both; 3 cycles each.
- jal → state 12 has pc_write=1, reg_write=1, jal=1, reg_ra=1, pc_src=10. jr → state 13 has pc_src=11 and reg_write=0.
- CNT_W=4, 16 back-to-back j instructions → instr_count returns to 0 (wraps 15→0); FETCH stall with mem_ready=0 keeps ir_write=0 and pc_write=0.
